maxpool2x2_stream: RTL and testbench
====================================

// Module: maxpool2x2_stream
// PURPOSE
// - Streaming 2x2, stride-2 max-pooling of FP16 feature maps, for NUM_CH channels in parallel.
// - Replaces the whole-frame-input pooling stage: pixels arrive in raster order over valid/ready.
// - Each pooled result leaves over valid/ready as soon as its 2x2 window completes.
// - Storage is one line buffer of IMG_W/2 partial maxima; no full-frame storage.
// - Sits between a conv layer output stream and the next layer's input FIFO in the U-Net encoder.
// PARAMETERS
// - DATA_WIDTH  16   element width; FP16 (1/5/10).
// - NUM_CH      1    channels packed per beat; channel c at bits [c*DATA_WIDTH +: DATA_WIDTH].
// - IMG_W       256  input columns; must be even and >=2.
// - IMG_H       256  input rows; must be even and >=2.
// - RELU_EN     0    1: clamp negative pooled results (sign=1, not NaN) to +0 (16'h0000).
// PORTS
// - clk        in   1                clock, rising edge
// - reset      in   1                asynchronous, active-high
// - soft_clr   in   1                synchronous frame restart
// - in_valid   in   1                input beat valid
// - in_ready   out  1                input beat accepted when in_valid & in_ready
// - in_data    in   NUM_CH*DW        one pixel, all channels
// - out_valid  out  1                pooled beat valid
// - out_ready  in   1                downstream accept
// - out_data   out  NUM_CH*DW        pooled pixel
// - out_last   out  1                qualifies out_data: last pooled pixel of the frame
// - busy       out  1                frame in progress (any beat accepted since frame start)
// BEHAVIOUR
// - Reset values: in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0; col=row=0.
// - Line buffer contents are not reset.
// - Counters col in [0,IMG_W-1] and row in [0,IMG_H-1] advance only on an accepted beat.
//   - col wraps to 0 with row+1.
//   - row wraps to 0 after (IMG_H-1, IMG_W-1): the next frame begins with no gap.
// - Even col: latch per-channel pixel into a pair register.
// - Odd col: m = max(pair, pixel).
//   - Even row: write m to linebuf[col>>1].
//   - Odd row: result = max(linebuf[col>>1], m).
//     - Result is loaded into the output register; out_valid=1 on the next cycle (latency 1).
// - Handshake: in_ready = ~soft_clr & (~out_valid | out_ready).
//   - No input is taken while a result is stalled.
//   - Throughput is 1 beat/cycle when out_ready=1.
//   - out_valid is held with out_data stable until out_ready is seen.
// - out_last=1 on the result from input (row=IMG_H-1, col=IMG_W-1).
//   - Exactly (IMG_W/2)*(IMG_H/2) outputs per frame.
// - busy: set on the first accepted beat of a frame; cleared when the out_last beat handshakes.
// - FP16 max: order by key, where key = x[15] ? ~x : {1'b1, x[14:0]}; take the larger key.
//   - On equal keys the earlier operand wins.
//   - +0 beats -0; NaN is ordered by bit pattern and passed through unchanged.
//   - Compare order: (a0,a1), then (b0,b1), then row-pair max.
// - RELU_EN: applied after the max, per channel, before the output register.
// - soft_clr (synchronous, highest priority):
//   - Effect: col=row=0, out_valid=0, out_last=0, busy=0.
//   - Same-cycle input beat: not accepted, because in_ready is low.
//   - Same-cycle pending output: dropped.
// - reset mid-frame: same effect as soft_clr, but asynchronous.
// - Back-pressure at frame boundary: a stalled out_last beat blocks the first beat of the next frame.
// STRUCTURE
// - Package maxpool_pkg holds:
//   - FP16 constants: FP16_POS_ZERO=16'h0000, FP16_SIGN_BIT=15.
//   - function fp16_key.
//   - Parameter-check macros (IMG_W/IMG_H even).
// - Sub-module fp16_max2 (combinational): inputs a, b; output y = larger key, a on tie.
//   - Instantiated 2*NUM_CH times: one for the column pair, one for the row pair.
// - Line buffer: reg array [IMG_W/2] of NUM_CH*DW; 1 write or 1 read per accepted odd-col beat.
//   - Never both for the same address in one cycle.
// - Counter widths: $clog2(IMG_W), $clog2(IMG_H).
// TESTING
// - 4x4, NUM_CH=1, input = raster values 1..16 as FP16, out_ready=1:
//   - outputs 6,8,14,16; out_last only on 16; 4 outputs; busy falls after.
// - Signs:
//   - Window {-1.0(BC00), -2.0(C000), -0.5(B800), -3.0(C200)} -> B800.
//   - Window {+0(0000), -0(8000), -1, -1} -> 0000.
//   - With RELU_EN=1, window all -2.0 -> 0000.
// - Back-pressure: out_ready random 30% high over two back-to-back 8x8 frames:
//   - in_ready low whenever out_valid&~out_ready.
//   - out_data stable while stalled.
//   - 32 outputs match the golden model.
// - NUM_CH=4, each channel different ramp: each lane pooled independently; lanes not swapped.
// - soft_clr asserted at row 2 col 3 of a 4x4 frame with in_valid=1:
//   - that beat is not accepted; pending output dropped.
//   - A fresh full frame then yields the correct 4 outputs.
// - Async reset pulse mid-cycle during an odd row: all outputs return to reset values immediately.
//   - The next frame pools correctly despite stale line-buffer contents.

Source files
------------

// File: rtl/maxpool2x2_stream_pkg.sv
// Shared FP16 helpers for the streaming 2x2 max-pool block.
// Latency: n/a (constants, functions and elaboration-time check macros only).
// Backpressure: n/a.
// Ports: none. Provides FP16_POS_ZERO, FP16_SIGN_BIT, fp16_key(), fp16_is_nan()
// and the MAXPOOL_CHECK_EVEN macro used by the top to reject odd image sizes.

`ifndef MAXPOOL_PKG_SV
`define MAXPOOL_PKG_SV

// Elaboration guard: pooling windows only tile an even dimension of at least 2.
`define MAXPOOL_CHECK_EVEN(LBL, VAL) \
  if ((((VAL) % 2) != 0) || ((VAL) < 2)) begin : LBL \
    $error("maxpool2x2_stream: image dimension must be even and >= 2"); \
  end

package maxpool_pkg;

  localparam logic [15:0] FP16_POS_ZERO = 16'h0000;
  localparam int          FP16_SIGN_BIT = 15;

  // Monotonic ordering key: negatives are bit-inverted so that more-negative
  // values sort lower; positives get the top bit forced so they sort above
  // every negative. +0 therefore beats -0, and NaNs order by bit pattern.
  function automatic logic [15:0] fp16_key(input logic [15:0] x);
    return x[FP16_SIGN_BIT] ? ~x : {1'b1, x[14:0]};
  endfunction

  function automatic logic fp16_is_nan(input logic [15:0] x);
    return (x[14:10] == 5'h1f) && (x[9:0] != 10'd0);
  endfunction

endpackage

`endif

// File: rtl/maxpool2x2_stream_if.sv
// Valid/ready stream bundle for the 2x2 max-pool block (input and output side).
// Latency: n/a (wires only).
// Backpressure: in_ready / out_ready carry flow control in each direction.
// Ports: in_valid/in_ready/in_data (pixel in), out_valid/out_ready/out_data/out_last
// (pooled pixel out). W must equal NUM_CH*DATA_WIDTH of the attached block.
// slave = the pooling block's view, master = the producer/consumer view.

interface maxpool2x2_stream_if #(
  parameter int W = 16
) ();

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/maxpool2x2_stream_fp16_max2.sv
// Combinational FP16 max of two operands using the package ordering key.
// Latency: 0 cycles (pure combinational).
// Backpressure: n/a.
// Ports: a (earlier operand), b (later operand), y = operand with the larger key;
// a wins on equal keys.

module fp16_max2
  import maxpool_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  // Strict compare keeps the earlier operand on a tie.
  assign y = (fp16_key(b) > fp16_key(a)) ? b : a;

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 FP16 max-pool, NUM_CH lanes per beat, raster-order input.
// Latency: 1 cycle from the accepted beat completing a window to out_valid.
// Backpressure: in_ready drops while a result is stalled or soft_clr is high.
// Ports: clk, reset (async, active-high), soft_clr (sync frame restart),
// strm (slave side of maxpool2x2_stream_if), busy (frame in progress).

module maxpool2x2_stream
  import maxpool_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 1,
  parameter int IMG_W      = 256,
  parameter int IMG_H      = 256,
  parameter bit RELU_EN    = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 soft_clr,
  maxpool2x2_stream_if.slave   strm,
  output logic                 busy
);

  localparam int DW       = DATA_WIDTH;
  localparam int BW       = NUM_CH * DW;
  localparam int CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LB_DEPTH = IMG_W / 2;
  localparam int LW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  `MAXPOOL_CHECK_EVEN(g_chk_img_w, IMG_W)
  `MAXPOOL_CHECK_EVEN(g_chk_img_h, IMG_H)
  if (DATA_WIDTH != 16) begin : g_chk_dw
    $error("maxpool2x2_stream: only FP16 (DATA_WIDTH=16) is supported");
  end

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          col_last;
  logic          row_last;
  logic          accept;

  logic [BW-1:0] pair_q;
  logic [BW-1:0] linebuf [LB_DEPTH];
  logic [LW-1:0] lb_idx;
  logic [BW-1:0] lb_rd;
  logic [BW-1:0] col_max;
  logic [BW-1:0] row_max;
  logic [BW-1:0] pooled;

  logic          out_valid_q;
  logic          out_last_q;
  logic [BW-1:0] out_data_q;
  logic          busy_q;

  assign strm.in_ready  = ~soft_clr & (~out_valid_q | strm.out_ready);
  assign strm.out_valid = out_valid_q;
  assign strm.out_data  = out_data_q;
  assign strm.out_last  = out_last_q;
  assign busy           = busy_q;

  assign accept   = strm.in_valid & strm.in_ready;
  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));
  assign lb_idx   = LW'(col >> 1);
  assign lb_rd    = linebuf[lb_idx];

  // Per lane: column pair first, then the stored upper-row maximum against it.
  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_lane
    fp16_max2 u_col_max (
      .a (pair_q[ch*DW +: DW]),
      .b (strm.in_data[ch*DW +: DW]),
      .y (col_max[ch*DW +: DW])
    );

    fp16_max2 u_row_max (
      .a (lb_rd[ch*DW +: DW]),
      .b (col_max[ch*DW +: DW]),
      .y (row_max[ch*DW +: DW])
    );

    // Negative non-NaN results clamp to +0 when ReLU is enabled.
    assign pooled[ch*DW +: DW] =
      (RELU_EN && row_max[ch*DW + FP16_SIGN_BIT] && !fp16_is_nan(row_max[ch*DW +: DW]))
        ? FP16_POS_ZERO : row_max[ch*DW +: DW];
  end

  // Datapath storage is deliberately unreset: every entry is rewritten
  // before it is read within a frame.
  always_ff @(posedge clk) begin
    if (accept && !col[0]) begin
      pair_q <= strm.in_data;
    end
    if (accept && col[0] && !row[0]) begin
      linebuf[lb_idx] <= col_max;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col         <= '0;
      row         <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else if (soft_clr) begin
      col         <= '0;
      row         <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // Retire the current result first so a same-cycle accept of the next
      // frame's first beat can re-arm busy.
      if (out_valid_q && strm.out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
        if (out_last_q) begin
          busy_q <= 1'b0;
        end
      end
      if (accept) begin
        busy_q <= 1'b1;
        if (col[0] && row[0]) begin
          out_valid_q <= 1'b1;
          out_data_q  <= pooled;
          out_last_q  <= row_last && col_last;
        end
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Self-checking bench for maxpool2x2_stream: three instances (4x4 1-lane,
// 8x8 4-lane, 4x4 1-lane with ReLU) driven through one shared stimulus path.
// Expected results come from a window-level reference model over a frame array.

module tb_maxpool2x2_stream;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]  sel;
  logic        drv_valid;
  logic        drv_ordy;
  logic        drv_clr;
  logic [63:0] drv_data;

  logic        busy_a, busy_b, busy_c;
  logic        obs_in_ready, obs_out_valid, obs_out_last, obs_busy;
  logic [63:0] obs_out_data;

  maxpool2x2_stream_if #(.W(16)) if_a ();
  maxpool2x2_stream_if #(.W(64)) if_b ();
  maxpool2x2_stream_if #(.W(16)) if_c ();

  assign if_a.in_valid  = drv_valid && (sel == 2'd0);
  assign if_a.in_data   = drv_data[15:0];
  assign if_a.out_ready = drv_ordy && (sel == 2'd0);
  assign if_b.in_valid  = drv_valid && (sel == 2'd1);
  assign if_b.in_data   = drv_data;
  assign if_b.out_ready = drv_ordy && (sel == 2'd1);
  assign if_c.in_valid  = drv_valid && (sel == 2'd2);
  assign if_c.in_data   = drv_data[15:0];
  assign if_c.out_ready = drv_ordy && (sel == 2'd2);

  maxpool2x2_stream #(.DATA_WIDTH(16), .NUM_CH(1), .IMG_W(4), .IMG_H(4), .RELU_EN(1'b0)) u_a (
    .clk(clk), .reset(reset), .soft_clr(drv_clr && (sel == 2'd0)), .strm(if_a.slave), .busy(busy_a));
  maxpool2x2_stream #(.DATA_WIDTH(16), .NUM_CH(4), .IMG_W(8), .IMG_H(8), .RELU_EN(1'b0)) u_b (
    .clk(clk), .reset(reset), .soft_clr(drv_clr && (sel == 2'd1)), .strm(if_b.slave), .busy(busy_b));
  maxpool2x2_stream #(.DATA_WIDTH(16), .NUM_CH(1), .IMG_W(4), .IMG_H(4), .RELU_EN(1'b1)) u_c (
    .clk(clk), .reset(reset), .soft_clr(drv_clr && (sel == 2'd2)), .strm(if_c.slave), .busy(busy_c));

  always_comb begin
    obs_in_ready  = if_a.in_ready;
    obs_out_valid = if_a.out_valid;
    obs_out_data  = 64'(if_a.out_data);
    obs_out_last  = if_a.out_last;
    obs_busy      = busy_a;
    case (sel)
      2'd1: begin
        obs_in_ready  = if_b.in_ready;
        obs_out_valid = if_b.out_valid;
        obs_out_data  = if_b.out_data;
        obs_out_last  = if_b.out_last;
        obs_busy      = busy_b;
      end
      2'd2: begin
        obs_in_ready  = if_c.in_ready;
        obs_out_valid = if_c.out_valid;
        obs_out_data  = 64'(if_c.out_data);
        obs_out_last  = if_c.out_last;
        obs_busy      = busy_c;
      end
      default: ;
    endcase
  end

  int          vecs = 0;
  int          errs = 0;
  logic [15:0] img [0:7][0:7][0:3];
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  logic        exp_last_q[$];
  logic        got_last_q[$];
  logic        prev_stall;
  logic [63:0] prev_data;
  logic [15:0] ramp_exp [4] = '{16'h4600, 16'h4800, 16'h4B00, 16'h4C00};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    vecs++;
    assert (got === want) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // b strictly greater than a in FP16 total order (sign first, then magnitude).
  function automatic logic fgt(input logic [15:0] a, input logic [15:0] b);
    if (a[15] != b[15]) return a[15];
    if (!a[15]) return b > a;
    return b < a;
  endfunction

  function automatic logic [15:0] fmax(input logic [15:0] a, input logic [15:0] b);
    return fgt(a, b) ? b : a;
  endfunction

  function automatic logic [15:0] int_to_fp16(input int n);
    int e;
    logic [15:0] m;
    e = 0;
    while ((n >> (e + 1)) != 0) e++;
    m = 16'((n << 10) >> e);
    return {1'b0, 5'(e + 15), m[9:0]};
  endfunction

  function automatic logic [63:0] pix(input int r, input int c, input int nch);
    logic [63:0] p;
    p = '0;
    for (int ch = 0; ch < nch; ch++) p[ch*16 +: 16] = img[r][c][ch];
    return p;
  endfunction

  task automatic fill_ramp4();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) img[r][c][0] = int_to_fp16(r * 4 + c + 1);
  endtask

  task automatic fill_rand(input int w, input int h, input int nch);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        for (int ch = 0; ch < nch; ch++) img[r][c][ch] = 16'($urandom);
  endtask

  task automatic expect_frame(input int w, input int h, input int nch, input bit relu);
    logic [63:0] e;
    logic [15:0] m;
    for (int r = 0; r < h / 2; r++)
      for (int c = 0; c < w / 2; c++) begin
        e = '0;
        for (int ch = 0; ch < nch; ch++) begin
          m = fmax(fmax(img[2*r][2*c][ch], img[2*r][2*c+1][ch]),
                   fmax(img[2*r+1][2*c][ch], img[2*r+1][2*c+1][ch]));
          if (relu && m[15] && !((m[14:10] == 5'h1f) && (m[9:0] != 10'd0))) m = 16'h0000;
          e[ch*16 +: 16] = m;
        end
        exp_q.push_back(e);
        exp_last_q.push_back((r == h / 2 - 1) && (c == w / 2 - 1));
      end
  endtask

  task automatic cyc(input logic v, input logic [63:0] d, input logic ordy, input logic clr,
                     output logic acc);
    @(negedge clk);
    drv_valid = v;
    drv_data  = d;
    drv_ordy  = ordy;
    drv_clr   = clr;
    #1;
    if (prev_stall && obs_out_valid) chk("stall_data_stable", obs_out_data, prev_data);
    if (obs_out_valid && !ordy) chk("in_ready_low_stalled", 64'(obs_in_ready), 64'd0);
    if (obs_out_valid && ordy && !clr) begin
      got_q.push_back(obs_out_data);
      got_last_q.push_back(obs_out_last);
    end
    prev_stall = obs_out_valid & ~ordy;
    prev_data  = obs_out_data;
    acc = v & obs_in_ready;
  endtask

  task automatic send_beat(input logic [63:0] p, input logic bp);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 400) begin
      cyc(1'b1, p, bp ? ($urandom_range(0, 9) < 3) : 1'b1, 1'b0, acc);
      n++;
    end
    chk("send_accepted", 64'(acc), 64'd1);
  endtask

  task automatic send_range(input int w, input int nch, input int first, input int count,
                            input logic bp);
    for (int i = first; i < first + count; i++) send_beat(pix(i / w, i % w, nch), bp);
  endtask

  task automatic drain(input logic bp);
    logic acc;
    int n;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 2000) begin
      cyc(1'b0, 64'd0, bp ? ($urandom_range(0, 9) < 3) : 1'b1, 1'b0, acc);
      n++;
    end
  endtask

  task automatic flush();
    exp_q.delete();
    got_q.delete();
    exp_last_q.delete();
    got_last_q.delete();
    prev_stall = 1'b0;
  endtask

  task automatic compare(input string tag);
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk({tag, "_data"}, got_q[i], exp_q[i]);
      chk({tag, "_last"}, 64'(got_last_q[i]), 64'(exp_last_q[i]));
    end
    flush();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 64'(obs_in_ready), 64'd1);
    chk({tag, "_out_valid"}, 64'(obs_out_valid), 64'd0);
    chk({tag, "_out_data"}, obs_out_data, 64'd0);
    chk({tag, "_out_last"}, 64'(obs_out_last), 64'd0);
    chk({tag, "_busy"}, 64'(obs_busy), 64'd0);
  endtask

  initial begin
    logic acc;
    reset      = 1'b1;
    sel        = 2'd0;
    drv_valid  = 1'b0;
    drv_ordy   = 1'b1;
    drv_clr    = 1'b0;
    drv_data   = '0;
    prev_stall = 1'b0;
    prev_data  = '0;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_vals("reset");
    reset = 1'b0;

    // Ramp 1..16 on the 4x4 single-lane instance.
    fill_ramp4();
    expect_frame(4, 4, 1, 1'b0);
    send_range(4, 1, 0, 16, 1'b0);
    cyc(1'b0, 64'd0, 1'b1, 1'b0, acc);
    chk("busy_before_last_hs", 64'(obs_busy), 64'd1);
    drain(1'b0);
    cyc(1'b0, 64'd0, 1'b1, 1'b0, acc);
    chk("busy_after_frame", 64'(obs_busy), 64'd0);
    chk("ramp_count", 64'(got_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) chk("ramp_value", got_q[i], 64'(ramp_exp[i]));
    compare("ramp");

    // Sign handling: all-negative window and a +0/-0 window.
    fill_rand(4, 4, 1);
    img[0][0][0] = 16'hBC00; img[0][1][0] = 16'hC000;
    img[1][0][0] = 16'hB800; img[1][1][0] = 16'hC200;
    img[0][2][0] = 16'h0000; img[0][3][0] = 16'h8000;
    img[1][2][0] = 16'hBC00; img[1][3][0] = 16'hBC00;
    expect_frame(4, 4, 1, 1'b0);
    send_range(4, 1, 0, 16, 1'b0);
    drain(1'b0);
    if (got_q.size() >= 2) begin
      chk("neg_window", got_q[0], 64'h0000_0000_0000_B800);
      chk("zero_window", got_q[1], 64'h0);
    end
    compare("signs");

    // soft_clr while a result is stalled: the result is dropped.
    fill_ramp4();
    send_range(4, 1, 0, 8, 1'b0);
    cyc(1'b0, 64'd0, 1'b0, 1'b0, acc);
    chk("pending_before_clr", 64'(obs_out_valid), 64'd1);
    cyc(1'b0, 64'd0, 1'b0, 1'b1, acc);
    cyc(1'b0, 64'd0, 1'b1, 1'b0, acc);
    chk("clr_drops_valid", 64'(obs_out_valid), 64'd0);
    chk("clr_busy", 64'(obs_busy), 64'd0);
    flush();

    // soft_clr at row 2 col 3 with a beat offered: the beat is refused.
    send_range(4, 1, 0, 11, 1'b0);
    cyc(1'b1, pix(2, 3, 1), 1'b1, 1'b1, acc);
    chk("clr_beat_refused", 64'(acc), 64'd0);
    cyc(1'b0, 64'd0, 1'b1, 1'b0, acc);
    chk("clr2_out_valid", 64'(obs_out_valid), 64'd0);
    chk("clr2_busy", 64'(obs_busy), 64'd0);
    flush();
    expect_frame(4, 4, 1, 1'b0);
    send_range(4, 1, 0, 16, 1'b0);
    drain(1'b0);
    compare("after_clr");

    // ReLU instance: an all -2.0 window clamps to +0.
    sel = 2'd2;
    flush();
    fill_rand(4, 4, 1);
    img[0][0][0] = 16'hC000; img[0][1][0] = 16'hC000;
    img[1][0][0] = 16'hC000; img[1][1][0] = 16'hC000;
    expect_frame(4, 4, 1, 1'b1);
    send_range(4, 1, 0, 16, 1'b0);
    drain(1'b0);
    if (got_q.size() >= 1) chk("relu_neg2", got_q[0], 64'h0);
    compare("relu");

    // 4-lane 8x8: two back-to-back frames under random 30% out_ready.
    sel = 2'd1;
    flush();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        for (int ch = 0; ch < 4; ch++) img[r][c][ch] = 16'(ch * 4096 + (ch + 1) * (r * 8 + c) + 1);
    expect_frame(8, 8, 4, 1'b0);
    send_range(8, 4, 0, 64, 1'b1);
    fill_rand(8, 8, 4);
    expect_frame(8, 8, 4, 1'b0);
    send_range(8, 4, 0, 64, 1'b1);
    drain(1'b1);
    chk("bp_total_outputs", 64'(got_q.size()), 64'd32);
    compare("backpressure");

    // Async reset pulse during an odd row with a result pending.
    sel = 2'd0;
    drv_ordy = 1'b1;
    flush();
    fill_rand(4, 4, 1);
    send_range(4, 1, 0, 6, 1'b0);
    @(negedge clk);
    drv_valid = 1'b0;
    drv_ordy  = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk_reset_vals("async_reset");
    #1 reset = 1'b0;
    flush();
    fill_rand(4, 4, 1);
    expect_frame(4, 4, 1, 1'b0);
    send_range(4, 1, 0, 16, 1'b0);
    drain(1'b0);
    compare("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
